// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// the size-to-byte-count helper.
package lsu_pkg;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC1 = 2'd1,
        ACC2 = 2'd2,
        RESP = 2'd3
    } state_e;

    // Reserved size code 3 behaves as a word access.
    function automatic logic [2:0] nbytes(input logic [1:0] size);
        case (size)
            SIZE_B:  nbytes = 3'd1;
            SIZE_H:  nbytes = 3'd2;
            SIZE_W:  nbytes = 3'd4;
            default: nbytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/lsu_mem_port_if.sv
// Request/response handshake and RAM port of the load/store unit, bundled.
// slave = the LSU's view, master = the CPU + RAM environment's view.
interface lsu_mem_port_if #(
    parameter int AWIDTH = 14
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [AWIDTH+1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic [AWIDTH-1:0] mem_addr;
    logic [31:0]       mem_d;
    logic [3:0]        mem_wbe;
    logic              mem_wen;
    logic [31:0]       mem_q;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_q,
        output req_ready, rsp_valid, rsp_rdata, mem_addr, mem_d, mem_wbe, mem_wen
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_q,
        input  req_ready, rsp_valid, rsp_rdata, mem_addr, mem_d, mem_wbe, mem_wen
    );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane alignment: write mask and shifted store data spanning two words,
// plus right-justified, sign/zero-extended load data from two captured words.
module lsu_align (
    input  logic [1:0]  off_i,
    input  logic [2:0]  nbytes_i,
    input  logic        sext_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] lo_i,
    input  logic [31:0] hi_i,
    output logic [7:0]  wmask8_o,
    output logic [63:0] wdat64_o,
    output logic [31:0] rdata_o
);

    logic [7:0]  base_mask_s;
    logic [5:0]  shamt_s;
    logic [31:0] raw_s;

    assign shamt_s = {off_i, 3'b000};

    // Contiguous byte mask before lane shift.
    always_comb begin
        case (nbytes_i)
            3'd1:    base_mask_s = 8'h01;
            3'd2:    base_mask_s = 8'h03;
            default: base_mask_s = 8'h0F;
        endcase
    end

    assign wmask8_o = base_mask_s << off_i;
    assign wdat64_o = {32'd0, wdata_i} << shamt_s;
    assign raw_s    = 32'({hi_i, lo_i} >> shamt_s);

    // Truncate to the access size and extend the top bit when signed.
    always_comb begin
        case (nbytes_i)
            3'd1:    rdata_o = {{24{sext_i & raw_s[7]}}, raw_s[7:0]};
            3'd2:    rdata_o = {{16{sext_i & raw_s[15]}}, raw_s[15:0]};
            default: rdata_o = raw_s;
        endcase
    end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store unit front end for a byte-enable word RAM: latches one request,
// issues one or two word accesses, then returns a single-cycle response.
module lsu_mem_port
    import lsu_pkg::*;
#(
    parameter int AWIDTH = 14,
    parameter int DWIDTH = 32
) (
    input logic           clk,
    input logic           rst,
    lsu_mem_port_if.slave bus
);

    state_e            state_q, state_d;

    logic              we_q;
    logic              uns_q;
    logic [1:0]        size_q;
    logic [AWIDTH+1:0] addr_q;
    logic [DWIDTH-1:0] wdata_q;
    logic [DWIDTH-1:0] lo_buf_q;
    logic [DWIDTH-1:0] hi_buf_q;

    logic [AWIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DWIDTH-1:0] mem_d_q, mem_d_d;
    logic [3:0]        mem_wbe_q, mem_wbe_d;
    logic              mem_wen_q, mem_wen_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DWIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

    logic              ready_s;
    logic              accept_s;
    logic              sel_we_s;
    logic              sel_uns_s;
    logic [1:0]        sel_size_s;
    logic [AWIDTH+1:0] sel_addr_s;
    logic [DWIDTH-1:0] sel_wdata_s;
    logic [2:0]        nbytes_s;
    logic              sext_s;
    logic              split_s;
    logic [AWIDTH-1:0] word_s;
    logic [7:0]        wmask8_s;
    logic [63:0]       wdat64_s;
    logic [DWIDTH-1:0] rdata_ext_s;

    assign ready_s  = (state_q == IDLE) & ~rst;
    assign accept_s = bus.req_valid & ready_s;

    // In IDLE the decode looks at the live request so ACC1's RAM outputs can
    // be registered on the accept edge; afterwards it uses the latched copy.
    always_comb begin
        if (state_q == IDLE) begin
            sel_we_s    = bus.req_we;
            sel_uns_s   = bus.req_unsigned;
            sel_size_s  = bus.req_size;
            sel_addr_s  = bus.req_addr;
            sel_wdata_s = bus.req_wdata;
        end else begin
            sel_we_s    = we_q;
            sel_uns_s   = uns_q;
            sel_size_s  = size_q;
            sel_addr_s  = addr_q;
            sel_wdata_s = wdata_q;
        end
    end

    assign nbytes_s = nbytes(sel_size_s);
    assign sext_s   = ~sel_uns_s & (nbytes_s != 3'd4);
    assign word_s   = sel_addr_s[AWIDTH+1:2];
    assign split_s  = |wmask8_s[7:4];

    lsu_align u_align (
        .off_i    (sel_addr_s[1:0]),
        .nbytes_i (nbytes_s),
        .sext_i   (sext_s),
        .wdata_i  (sel_wdata_s),
        .lo_i     (lo_buf_q),
        .hi_i     (hi_buf_q),
        .wmask8_o (wmask8_s),
        .wdat64_o (wdat64_s),
        .rdata_o  (rdata_ext_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d = ACC1;
                end else begin
                    state_d = IDLE;
                end
            end
            ACC1: begin
                if (split_s) begin
                    state_d = ACC2;
                end else begin
                    state_d = RESP;
                end
            end
            ACC2:    state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output next values: RAM drive for the state being entered, response
    // for the cycle after RESP; address and data hold outside accesses.
    always_comb begin
        mem_addr_d  = mem_addr_q;
        mem_d_d     = mem_d_q;
        mem_wbe_d   = 4'h0;
        mem_wen_d   = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        case (state_d)
            ACC1: begin
                mem_addr_d = word_s;
                mem_wbe_d  = wmask8_s[3:0];
                mem_d_d    = wdat64_s[31:0];
                mem_wen_d  = sel_we_s;
            end
            ACC2: begin
                mem_addr_d = word_s + AWIDTH'(1);
                mem_wbe_d  = wmask8_s[7:4];
                mem_d_d    = wdat64_s[63:32];
                mem_wen_d  = sel_we_s;
            end
            default: begin
                mem_wbe_d = 4'h0;
                mem_wen_d = 1'b0;
            end
        endcase
        if (state_q == RESP) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = we_q ? '0 : rdata_ext_s;
        end else begin
            rsp_valid_d = 1'b0;
            rsp_rdata_d = '0;
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr_q  <= '0;
            mem_d_q     <= '0;
            mem_wbe_q   <= 4'h0;
            mem_wen_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            mem_addr_q  <= mem_addr_d;
            mem_d_q     <= mem_d_d;
            mem_wbe_q   <= mem_wbe_d;
            mem_wen_q   <= mem_wen_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Request latch, loaded on accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept_s) begin
            we_q    <= bus.req_we;
            uns_q   <= bus.req_unsigned;
            size_q  <= bus.req_size;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
        end
    end

    // Load capture of the asynchronous RAM read in each access cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            lo_buf_q <= '0;
            hi_buf_q <= '0;
        end else begin
            if ((state_q == ACC1) && !we_q) begin
                lo_buf_q <= bus.mem_q;
            end
            if ((state_q == ACC2) && !we_q) begin
                hi_buf_q <= bus.mem_q;
            end
        end
    end

    // Reset gates the write strobes immediately so a pending ACC2 write is dropped.
    assign bus.req_ready = ready_s;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_d     = mem_d_q;
    assign bus.mem_wbe   = mem_wbe_q & {4{~rst}};
    assign bus.mem_wen   = mem_wen_q & ~rst;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Bench for lsu_mem_port: RAM model on the port, byte-level golden memory,
// directed corner cases followed by randomized traffic.
module tb_lsu_mem_port;

    localparam int AW = 14;

    logic clk = 1'b0;
    logic rst = 1'b1;

    lsu_mem_port_if #(.AWIDTH(AW)) bus ();

    lsu_mem_port #(.AWIDTH(AW), .DWIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    logic [31:0] ram  [0:(1<<AW)-1];
    logic [7:0]  gold [0:(1<<(AW+2))-1];

    logic [AW-1:0] wr_addr [$];
    logic [3:0]    wr_wbe  [$];
    logic [31:0]   wr_d    [$];
    logic [31:0]   exp_q   [$];

    int          errors = 0;
    int          checks = 0;
    int          rsp_cnt = 0;
    logic [31:0] mon_e;
    logic [AW-1:0] acc1_addr, acc2_addr;
    logic [31:0] last_rdata;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int nbytes_of(input logic [1:0] s);
        if (s == 2'd0) return 1;
        if (s == 2'd1) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] s, input logic uns, input logic [15:0] a);
        int n;
        logic [31:0] v;
        logic [15:0] ba;
        n = nbytes_of(s);
        v = 32'd0;
        for (int i = 0; i < n; i++) begin
            ba = a + 16'(i);
            v = v | (32'(gold[ba]) << (8 * i));
        end
        if (!uns && n < 4 && v[8*n-1]) begin
            v = v | (32'hFFFF_FFFF << (8 * n));
        end
        return v;
    endfunction

    task automatic model_store(input logic [1:0] s, input logic [15:0] a, input logic [31:0] wd);
        logic [15:0] ba;
        for (int i = 0; i < nbytes_of(s); i++) begin
            ba = a + 16'(i);
            gold[ba] = wd[8*i +: 8];
        end
    endtask

    // RAM model: asynchronous read, per-byte synchronous write, write log.
    assign bus.mem_q = ram[bus.mem_addr];
    always @(posedge clk) begin
        if (bus.mem_wen) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.mem_wbe[b]) ram[bus.mem_addr][8*b +: 8] = bus.mem_d[8*b +: 8];
            end
            wr_addr.push_back(bus.mem_addr);
            wr_wbe.push_back(bus.mem_wbe);
            wr_d.push_back(bus.mem_d);
        end
    end

    // Response monitor against the expected-data queue.
    always @(negedge clk) begin
        if (bus.rsp_valid) begin
            rsp_cnt++;
            if (exp_q.size() == 0) begin
                check_eq("unexpected_rsp", 64'd1, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check_eq("rdata", 64'(bus.rsp_rdata), 64'(mon_e));
            end
        end
    end

    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [15:0] a, input logic [31:0] wd);
        int  waited, lat, exp_lat;
        bit  got;
        wr_addr.delete(); wr_wbe.delete(); wr_d.delete();
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_addr     = a;
        bus.req_wdata    = wd;
        waited = 0;
        while (!bus.req_ready && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.req_ready) begin
            check_eq("accept_timeout", 64'd0, 64'd1);
            bus.req_valid = 1'b0;
            return;
        end
        if (we) begin
            model_store(sz, a, wd);
            exp_q.push_back(32'd0);
        end else begin
            exp_q.push_back(model_load(sz, uns, a));
        end
        exp_lat = (int'(a[1:0]) + nbytes_of(sz) > 4) ? 3 : 2;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'($urandom);
        bus.req_size     = 2'($urandom);
        bus.req_unsigned = 1'($urandom);
        bus.req_addr     = 16'($urandom);
        bus.req_wdata    = $urandom;
        acc1_addr = bus.mem_addr;
        lat = 0;
        got = 1'b0;
        for (int k = 1; k <= 6 && !got; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 1) acc2_addr = bus.mem_addr;
            if (bus.rsp_valid) begin
                got = 1'b1;
                lat = k;
                last_rdata = bus.rsp_rdata;
            end
        end
        check_eq("latency", 64'(lat), 64'(exp_lat));
        @(negedge clk);
        check_eq("pulse_one_cycle", 64'(bus.rsp_valid), 64'd0);
    endtask

    initial begin
        logic [29:0] pat, exp_pat;
        logic [15:0] a;
        logic [31:0] w, exp_w;
        int acc, base;

        for (int i = 0; i < (1 << AW); i++) ram[i] = 32'd0;
        for (int i = 0; i < (1 << (AW + 2)); i++) gold[i] = 8'd0;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0;
        bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = 32'd0;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_ready", 64'(bus.req_ready), 64'd0);
        check_eq("rst_outputs", {bus.rsp_valid, bus.rsp_rdata, bus.mem_wen, bus.mem_wbe},
                 64'd0);
        check_eq("rst_mem", {bus.mem_addr, bus.mem_d}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("ready_after_rst", 64'(bus.req_ready), 64'd1);

        // Aligned word
        do_req(1'b1, 2'd2, 1'b0, 16'h0010, 32'hDEADBEEF);
        check_eq("sw_nwrites", 64'(wr_addr.size()), 64'd1);
        if (wr_addr.size() == 1) begin
            check_eq("sw_addr", 64'(wr_addr[0]), 64'd4);
            check_eq("sw_wbe", 64'(wr_wbe[0]), 64'hF);
            check_eq("sw_data", 64'(wr_d[0]), 64'hDEADBEEF);
        end
        do_req(1'b0, 2'd2, 1'b0, 16'h0010, 32'd0);
        check_eq("lw_value", 64'(last_rdata), 64'hDEADBEEF);
        check_eq("lw_nwrites", 64'(wr_addr.size()), 64'd0);

        // Byte extend
        do_req(1'b1, 2'd0, 1'b0, 16'h0013, 32'h00000080);
        if (wr_addr.size() == 1) begin
            check_eq("sb_wbe", 64'(wr_wbe[0]), 64'h8);
            check_eq("sb_lane", 64'(wr_d[0][31:24]), 64'h80);
        end else check_eq("sb_nwrites", 64'(wr_addr.size()), 64'd1);
        do_req(1'b0, 2'd0, 1'b0, 16'h0013, 32'd0);
        check_eq("lb_sext", 64'(last_rdata), 64'hFFFFFF80);
        do_req(1'b0, 2'd0, 1'b1, 16'h0013, 32'd0);
        check_eq("lbu_zext", 64'(last_rdata), 64'h00000080);

        // Split word
        do_req(1'b1, 2'd2, 1'b0, 16'h000E, 32'h11223344);
        if (wr_addr.size() == 2) begin
            check_eq("split_a1", 64'(wr_addr[0]), 64'd3);
            check_eq("split_wbe1", 64'(wr_wbe[0]), 64'hC);
            check_eq("split_d1", 64'(wr_d[0][31:16]), 64'h3344);
            check_eq("split_a2", 64'(wr_addr[1]), 64'd4);
            check_eq("split_wbe2", 64'(wr_wbe[1]), 64'h3);
            check_eq("split_d2", 64'(wr_d[1][15:0]), 64'h1122);
        end else check_eq("split_nwrites", 64'(wr_addr.size()), 64'd2);
        do_req(1'b0, 2'd2, 1'b0, 16'h000E, 32'd0);
        check_eq("split_lw", 64'(last_rdata), 64'h11223344);

        // Address wrap
        do_req(1'b1, 2'd2, 1'b0, 16'hFFFC, 32'hA1B2C3D4);
        do_req(1'b1, 2'd2, 1'b0, 16'h0000, 32'h5566778E);
        do_req(1'b0, 2'd1, 1'b0, 16'hFFFF, 32'd0);
        check_eq("wrap_acc1", 64'(acc1_addr), 64'h3FFF);
        check_eq("wrap_acc2", 64'(acc2_addr), 64'd0);
        check_eq("wrap_lh", 64'(last_rdata), 64'hFFFF8EA1);
        do_req(1'b0, 2'd1, 1'b1, 16'hFFFF, 32'd0);
        check_eq("wrap_lhu", 64'(last_rdata), 64'h00008EA1);

        // Back-to-back handshake with valid held high
        @(negedge clk);
        acc = 0; base = rsp_cnt; pat = '0; exp_pat = '0;
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'd2; bus.req_unsigned = 1'b0;
        for (int c = 0; c < 30; c++) begin
            bus.req_addr = 16'($urandom_range(0, 15)) << 2;
            exp_pat[c] = (c % 3 == 0);
            pat[c] = bus.req_ready;
            if (bus.req_ready) begin
                acc++;
                exp_q.push_back(model_load(2'd2, 1'b0, bus.req_addr));
            end
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("hs_accepts", 64'(acc), 64'd10);
        check_eq("hs_ready_pattern", 64'(pat), 64'(exp_pat));
        check_eq("hs_rsp_count", 64'(rsp_cnt - base), 64'd10);

        // Reset during ACC2 of a split store
        wr_addr.delete(); wr_wbe.delete(); wr_d.delete();
        base = rsp_cnt;
        w = $urandom;
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd2;
        bus.req_addr = 16'h002E; bus.req_wdata = w;
        check_eq("rm_ready", 64'(bus.req_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("rm_nwrites", 64'(wr_addr.size()), 64'd1);
        check_eq("rm_outputs", {bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.mem_wen, bus.mem_wbe},
                 64'd0);
        check_eq("rm_mem", {bus.mem_addr, bus.mem_d}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rm_ready_after", 64'(bus.req_ready), 64'd1);
        repeat (3) @(negedge clk);
        check_eq("rm_no_rsp", 64'(rsp_cnt - base), 64'd0);
        gold[16'h002E] = w[7:0];
        gold[16'h002F] = w[15:8];
        do_req(1'b0, 2'd2, 1'b0, 16'h002C, 32'd0);
        do_req(1'b0, 2'd2, 1'b0, 16'h0030, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 3) == 0) a = 16'($urandom_range(16'hFFF8, 16'hFFFF));
            else                          a = 16'($urandom_range(0, 47));
            do_req(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom);
        end
        repeat (3) @(negedge clk);
        check_eq("exp_queue_empty", 64'(exp_q.size()), 64'd0);

        // RAM contents against the golden byte image
        for (int wi = 0; wi < (1 << AW); wi++) begin
            if (wi < 16 || wi >= (1 << AW) - 4) begin
                exp_w = {gold[4*wi+3], gold[4*wi+2], gold[4*wi+1], gold[4*wi]};
                check_eq("ram_word", 64'(ram[wi]), 64'(exp_w));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
